// File: rtl/peripheral_if.sv
// CPU-side peripheral bus: read/write strobes, byte address, write data and combinational read data.
// The CPU drives the master modport and the peripheral block responds on the slave modport.
interface peripheral_if;
   logic        rd;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output rd, output wr, output addr, output wdata, input rdata);
   modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/peripheral.sv
// Timer/LED/7-seg/switch/systick register block; reads are combinational and writes land on the edge.
// Never stalls: every strobe completes in the cycle it is presented.
module peripheral #(
   parameter logic [31:0] BASE = 32'h4000_0000
) (
   input  logic         clk,
   input  logic         reset,
   peripheral_if.slave  bus,
   output logic         irqout,
   output logic [7:0]   led,
   input  logic [7:0]   switch,
   output logic [11:0]  digi
);

   localparam logic [31:0] A_TH      = BASE + 32'h00;
   localparam logic [31:0] A_TL      = BASE + 32'h04;
   localparam logic [31:0] A_TCON    = BASE + 32'h08;
   localparam logic [31:0] A_LED     = BASE + 32'h0C;
   localparam logic [31:0] A_SWITCH  = BASE + 32'h10;
   localparam logic [31:0] A_DIGI    = BASE + 32'h14;
   localparam logic [31:0] A_SYSTICK = BASE + 32'h18;

   logic [31:0] th_q, th_d;
   logic [31:0] tl_q, tl_d;
   logic [2:0]  tcon_q, tcon_d;
   logic [7:0]  led_q, led_d;
   logic [11:0] digi_q, digi_d;
   logic [31:0] systick_q;
   logic [7:0]  sw_meta_q, sw_sync_q;

   logic wr_th, wr_tl, wr_tcon, wr_led, wr_digi;

   assign wr_th   = bus.wr && (bus.addr == A_TH);
   assign wr_tl   = bus.wr && (bus.addr == A_TL);
   assign wr_tcon = bus.wr && (bus.addr == A_TCON);
   assign wr_led  = bus.wr && (bus.addr == A_LED);
   assign wr_digi = bus.wr && (bus.addr == A_DIGI);

   always_comb begin
      bus.rdata = 32'h0;
      if (bus.rd) begin
         case (bus.addr)
            A_TH:      bus.rdata = th_q;
            A_TL:      bus.rdata = tl_q;
            A_TCON:    bus.rdata = {29'h0, tcon_q};
            A_LED:     bus.rdata = {24'h0, led_q};
            A_SWITCH:  bus.rdata = {24'h0, sw_sync_q};
            A_DIGI:    bus.rdata = {20'h0, digi_q};
            A_SYSTICK: bus.rdata = systick_q;
            default:   bus.rdata = 32'h0;
         endcase
      end
   end

   // Timer step first, then bus writes so a same-cycle write always wins; reload uses the old TH.
   always_comb begin
      th_d   = th_q;
      tl_d   = tl_q;
      tcon_d = tcon_q;
      led_d  = led_q;
      digi_d = digi_q;
      if (tcon_q[0]) begin
         if (tl_q == 32'hFFFF_FFFF) begin
            tl_d = th_q;
            if (tcon_q[1]) begin
               tcon_d[2] = 1'b1;
            end
         end else begin
            tl_d = tl_q + 32'd1;
         end
      end
      if (wr_th)   th_d   = bus.wdata;
      if (wr_tl)   tl_d   = bus.wdata;
      if (wr_tcon) tcon_d = bus.wdata[2:0];
      if (wr_led)  led_d  = bus.wdata[7:0];
      if (wr_digi) digi_d = bus.wdata[11:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         th_q      <= 32'h0;
         tl_q      <= 32'h0;
         tcon_q    <= 3'h0;
         led_q     <= 8'h0;
         digi_q    <= 12'h0;
         systick_q <= 32'h0;
         sw_meta_q <= 8'h0;
         sw_sync_q <= 8'h0;
      end else begin
         th_q      <= th_d;
         tl_q      <= tl_d;
         tcon_q    <= tcon_d;
         led_q     <= led_d;
         digi_q    <= digi_d;
         systick_q <= systick_q + 32'd1;
         sw_meta_q <= switch;
         sw_sync_q <= sw_meta_q;
      end
   end

   assign irqout = tcon_q[1] & tcon_q[2];
   assign led    = led_q;
   assign digi   = digi_q;

endmodule

// File: tb/tb_peripheral.sv
// Directed bench for the peripheral register block with hand-computed expectations.
module tb_peripheral;
   localparam logic [31:0] BASE = 32'h4000_0000;
   localparam logic [31:0] A_TH = BASE + 32'h00, A_TL = BASE + 32'h04, A_TCON = BASE + 32'h08;
   localparam logic [31:0] A_LED = BASE + 32'h0C, A_SW = BASE + 32'h10, A_DIGI = BASE + 32'h14;
   localparam logic [31:0] A_ST = BASE + 32'h18;

   logic        clk = 1'b0;
   logic        reset;
   logic        irqout;
   logic [7:0]  led;
   logic [7:0]  sw;
   logic [11:0] digi;
   int          tests = 0;
   int          fails = 0;

   peripheral_if bus ();

   peripheral #(.BASE(BASE)) dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus),
      .irqout (irqout),
      .led    (led),
      .switch (sw),
      .digi   (digi)
   );

   always #5 clk = ~clk;

   task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
      tick();
      bus.wr = 1'b0;
   endtask

   task automatic chk_rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
      bus.rd = 1'b1; bus.addr = a;
      #1;
      check(bus.rdata, exp, tag);
      bus.rd = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
      sw = 8'h0;

      // Reset held with random bus and switch activity
      for (int i = 0; i < 6; i++) begin
         bus.rd    = 1'($urandom_range(0, 1));
         bus.wr    = 1'($urandom_range(0, 1));
         bus.addr  = BASE + {$urandom_range(0, 6), 2'b00};
         bus.wdata = $urandom;
         sw        = 8'($urandom);
         tick();
      end
      bus.wr = 1'b0; sw = 8'h0;
      check({31'h0, irqout}, 32'h0, "rst_irq");
      check({24'h0, led}, 32'h0, "rst_led");
      check({20'h0, digi}, 32'h0, "rst_digi");
      chk_rd(A_TL, 32'h0, "rst_tl");
      chk_rd(A_TCON, 32'h0, "rst_tcon");
      chk_rd(A_ST, 32'h0, "rst_systick");
      reset = 1'b1;
      repeat (5) tick();
      chk_rd(A_ST, 32'd5, "systick_5");

      // LED / DIGI
      wr(A_LED, 32'hFFFF_FFA5);
      check({24'h0, led}, 32'hA5, "led_out");
      wr(A_DIGI, 32'h0000_1F3C);
      check({20'h0, digi}, 32'hF3C, "digi_out");
      chk_rd(A_LED, 32'h0000_00A5, "led_rd");
      chk_rd(A_DIGI, 32'h0000_0F3C, "digi_rd");
      wr(A_SW, 32'hFFFF_FFFF);
      chk_rd(A_SW, 32'h0, "switch_ro");
      check({24'h0, led}, 32'hA5, "led_hold");

      // Simultaneous rd+wr: rdata shows pre-write value
      bus.rd = 1'b1; bus.wr = 1'b1; bus.addr = A_LED; bus.wdata = 32'h3C;
      #1;
      check(bus.rdata, 32'hA5, "rdwr_prewrite");
      tick();
      bus.rd = 1'b0; bus.wr = 1'b0;
      check({24'h0, led}, 32'h3C, "rdwr_led");

      // Timer reload and IRQ
      wr(A_TH, 32'hFFFF_FFFD);
      wr(A_TL, 32'hFFFF_FFFE);
      wr(A_TCON, 32'h3);
      chk_rd(A_TL, 32'hFFFF_FFFE, "tl_enable_edge");
      check({31'h0, irqout}, 32'h0, "irq_pre");
      tick();
      chk_rd(A_TL, 32'hFFFF_FFFF, "tl_ffff");
      tick();
      chk_rd(A_TL, 32'hFFFF_FFFD, "tl_reload");
      check({31'h0, irqout}, 32'h1, "irq_set");
      chk_rd(A_TCON, 32'h7, "tcon_status");
      wr(A_TCON, 32'h3);
      check({31'h0, irqout}, 32'h0, "irq_ack");
      chk_rd(A_TL, 32'hFFFF_FFFE, "tl_after_ack");
      tick();
      chk_rd(A_TL, 32'hFFFF_FFFF, "tl_continue");

      // Collision: TCON write on overflow edge wins
      wr(A_TCON, 32'h1);
      chk_rd(A_TCON, 32'h1, "coll_tcon");
      check({31'h0, irqout}, 32'h0, "coll_irq");
      chk_rd(A_TL, 32'hFFFF_FFFD, "coll_tl_reload");
      // TL write during counting
      wr(A_TL, 32'h0000_1234);
      chk_rd(A_TL, 32'h0000_1234, "tl_write_wins");
      tick();
      chk_rd(A_TL, 32'h0000_1235, "tl_inc_after_wr");
      // TH write during overflow: reload uses old TH
      wr(A_TL, 32'hFFFF_FFFF);
      wr(A_TH, 32'h0000_0100);
      chk_rd(A_TL, 32'hFFFF_FFFD, "reload_old_th");
      chk_rd(A_TH, 32'h0000_0100, "th_new");

      // Switch synchronizer
      sw = 8'h5A;
      tick();
      chk_rd(A_SW, 32'h0, "sw_1edge");
      tick();
      chk_rd(A_SW, 32'h5A, "sw_2edge");

      // Decode
      chk_rd(BASE + 32'h1C, 32'h0, "unmapped_1c");
      chk_rd(BASE + 32'h02, 32'h0, "unaligned_02");
      chk_rd(32'h0000_0008, 32'h0, "outside_window");
      bus.rd = 1'b0; bus.addr = A_LED;
      #1;
      check(bus.rdata, 32'h0, "rd_low");

      // Reset mid-count with a pending IRQ
      wr(A_TCON, 32'h3);
      wr(A_TL, 32'hFFFF_FFFF);
      tick();
      check({31'h0, irqout}, 32'h1, "irq_before_rst");
      #2 reset = 1'b0;
      #1;
      check({31'h0, irqout}, 32'h0, "rst_mid_irq");
      chk_rd(A_TL, 32'h0, "rst_mid_tl");
      chk_rd(A_TCON, 32'h0, "rst_mid_tcon");
      check({24'h0, led}, 32'h0, "rst_mid_led");
      reset = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
